xotr_io_sequencer: RTL

Sequencer for the register-indirect port transfers `IN r,(C)` and `OUT (C),r`, plus their block-repeat forms (`INIR`/`OTIR`-style). It sits in the XOTR decode path, downstream of opcode fetch. It replaces the fixed four-T-state combinational port decode with a clocked controller that has:
- a parametrised phase count,
- bounded device wait-state insertion,
- a B-counted repeat loop.

It drives the bus phase strobes, register select/write enables and the flag write, and hands control back to the M1 fetch.

---
 rtl/xotr_io_sequencer_pkg.sv | 39 +++
 rtl/xotr_io_sequencer_if.sv | 44 ++++
 rtl/xotr_io_sequencer_reg_decode.sv | 32 +++
 rtl/xotr_io_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/xotr_io_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xotr_io_pkg
// Purpose  : Shared types and encodings for the XOTR port-transfer sequencer.
// Revision : 1.0  initial release
// ============================================================================
package xotr_io_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_PHASE = 3'd2,
        ST_WAITS = 3'd3,
        ST_WB    = 3'd4,
        ST_FIN   = 3'd5
    } state_t;

    // r-field encodings as they appear in the opcode
    localparam logic [2:0] REG_B    = 3'b000;
    localparam logic [2:0] REG_C    = 3'b001;
    localparam logic [2:0] REG_D    = 3'b010;
    localparam logic [2:0] REG_E    = 3'b011;
    localparam logic [2:0] REG_H    = 3'b100;
    localparam logic [2:0] REG_L    = 3'b101;
    localparam logic [2:0] REG_NONE = 3'b110;
    localparam logic [2:0] REG_A    = 3'b111;

    // Bit positions inside sel_data / write_reg
    localparam int SEL_B = 0;
    localparam int SEL_C = 1;
    localparam int SEL_D = 2;
    localparam int SEL_E = 3;
    localparam int SEL_H = 4;
    localparam int SEL_L = 5;
    localparam int SEL_A = 6;
    localparam int SEL_W = 7;

endpackage
`default_nettype wire

// File: rtl/xotr_io_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : xotr_io_sequencer_if
// Purpose  : Control/status bundle between decode and the port-transfer sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface xotr_io_sequencer_if #(
    parameter int PHASES = 4
);
    import xotr_io_pkg::*;

    logic              start;
    logic              dir;
    logic [2:0]        reg_sel;
    logic              block_mode;
    logic [15:0]       bc;
    logic              notWAIT;

    logic              busy;
    logic              sel_addr_bc;
    logic [PHASES-1:0] io_in_phase;
    logic [PHASES-1:0] io_out_phase;
    logic [SEL_W-1:0]  sel_data;
    logic [SEL_W-1:0]  write_reg;
    logic              flags_write;
    logic              dec_b;
    logic              wait_timeout;
    logic              done;
    logic              set_cm1;

    modport master (
        output start, dir, reg_sel, block_mode, bc, notWAIT,
        input  busy, sel_addr_bc, io_in_phase, io_out_phase, sel_data,
               write_reg, flags_write, dec_b, wait_timeout, done, set_cm1
    );

    modport slave (
        input  start, dir, reg_sel, block_mode, bc, notWAIT,
        output busy, sel_addr_bc, io_in_phase, io_out_phase, sel_data,
               write_reg, flags_write, dec_b, wait_timeout, done, set_cm1
    );

endinterface
`default_nettype wire

// File: rtl/xotr_io_sequencer_reg_decode.sv
`default_nettype none
// ============================================================================
// Module   : xotr_reg_decode
// Purpose  : r-field to one-hot register select; zero when disabled or r=110.
// Revision : 1.0  initial release
// ============================================================================
module xotr_reg_decode
    import xotr_io_pkg::*;
(
    input  wire logic             en_i,
    input  wire logic [2:0]       reg_sel_i,
    output logic      [SEL_W-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            case (reg_sel_i)
                REG_B:    onehot_o[SEL_B] = 1'b1;
                REG_C:    onehot_o[SEL_C] = 1'b1;
                REG_D:    onehot_o[SEL_D] = 1'b1;
                REG_E:    onehot_o[SEL_E] = 1'b1;
                REG_H:    onehot_o[SEL_H] = 1'b1;
                REG_L:    onehot_o[SEL_L] = 1'b1;
                REG_A:    onehot_o[SEL_A] = 1'b1;
                default:  onehot_o = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/xotr_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : xotr_io_sequencer
// Purpose  : Clocked controller for IN r,(C) / OUT (C),r and their repeat forms.
// Revision : 1.0  initial release
// ============================================================================
module xotr_io_sequencer
    import xotr_io_pkg::*;
#(
    parameter int PHASES   = 4,
    parameter int WAIT_MAX = 7
) (
    input  wire logic          CLK,
    input  wire logic          notRESET,
    xotr_io_sequencer_if.slave io
);

    localparam int PW = $clog2(PHASES);
    localparam int WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;

    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [PW-1:0] P_TWO  = PW'(2);
    localparam logic [PW-1:0] P_LAST = PW'(PHASES - 1);
    localparam logic [WW-1:0] W_LAST = WW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    state_t         state_q, state_d;
    logic [PW-1:0]  phase_q, phase_d;
    logic [WW-1:0]  wait_q,  wait_d;
    logic           dir_q,   dir_d;
    logic [2:0]     reg_q,   reg_d;
    logic           block_q, block_d;

    logic              w_active;
    logic              w_in_wb;
    logic [PHASES-1:0] w_strobe;
    logic [7:0]        w_b;
    logic              w_unused_bc_low;

    assign w_b             = io.bc[15:8];
    assign w_unused_bc_low = ^io.bc[7:0];

    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            wait_q  <= '0;
            dir_q   <= 1'b0;
            reg_q   <= REG_NONE;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wait_q  <= wait_d;
            dir_q   <= dir_d;
            reg_q   <= reg_d;
            block_q <= block_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        dir_d   = dir_q;
        reg_d   = reg_q;
        block_d = block_q;
        unique case (state_q)
            ST_IDLE: begin
                if (io.start) begin
                    state_d = ST_ADDR;
                    dir_d   = io.dir;
                    reg_d   = io.reg_sel;
                    block_d = io.block_mode;
                end
            end
            ST_ADDR: begin
                state_d = ST_PHASE;
                phase_d = '0;
            end
            ST_PHASE: begin
                if ((phase_q == P_ONE) && !io.notWAIT && (WAIT_MAX > 0)) begin
                    state_d = ST_WAITS;
                    wait_d  = '0;
                end else if (phase_q == P_LAST) begin
                    state_d = ST_WB;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_WAITS: begin
                // The limit releases the device exactly as if notWAIT had gone high
                if (io.notWAIT || (wait_q == W_LAST)) begin
                    if (PHASES == 2) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_PHASE;
                        phase_d = P_TWO;
                    end
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            ST_WB: begin
                // B is tested before its decrement lands, so B=0 wraps to 256 passes
                if (block_q && (w_b != 8'd1)) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign w_active = (state_q == ST_PHASE) || (state_q == ST_WAITS);
    assign w_in_wb  = (state_q == ST_WB);
    assign w_strobe = w_active ? (PHASES'(1) << phase_q) : '0;

    assign io.busy         = (state_q != ST_IDLE);
    assign io.sel_addr_bc  = (state_q == ST_ADDR) || w_active;
    assign io.io_in_phase  = dir_q ? '0 : w_strobe;
    assign io.io_out_phase = dir_q ? w_strobe : '0;
    assign io.flags_write  = w_in_wb && !dir_q;
    assign io.dec_b        = w_in_wb && block_q;
    assign io.wait_timeout = (state_q == ST_WAITS) && (wait_q == W_LAST);
    assign io.done         = (state_q == ST_FIN);
    assign io.set_cm1      = (state_q == ST_FIN);

    xotr_reg_decode u_sel_data (
        .en_i      (w_active && dir_q),
        .reg_sel_i (reg_q),
        .onehot_o  (io.sel_data)
    );

    xotr_reg_decode u_write_reg (
        .en_i      (w_in_wb && !dir_q),
        .reg_sel_i (reg_q),
        .onehot_o  (io.write_reg)
    );

endmodule
`default_nettype wire
